// File: rtl/sim_mmio_bridge_pkg.sv
// Shared types and default address map for the simulation MMIO bridge.
package sim_mmio_bridge_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned CYCLE_W       = 32;
  localparam logic [XLEN-1:0] MEM_BASE_DEF  = 32'h0002_0000;
  localparam int unsigned MEM_SIZE_DEF  = 16384;
  localparam logic [XLEN-1:0] MMIO_BASE_DEF = 32'hFFFF_FFF0;

  // Register offsets inside the 16-byte MMIO page
  typedef enum logic [3:0] {
    EXIT    = 4'h0,
    CONSOLE = 4'h4,
    CYCLE   = 4'h8
  } mmio_off_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RESP     = 2'd2
  } bridge_state_e;

  // Registered response payload for MMIO / error replies
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            error;
  } resp_t;

endpackage

// File: rtl/sim_mmio_bridge_if.sv
// Core-side request/response and data-memory-side bus bundle.
interface sim_mmio_bridge_if #(
  parameter int unsigned xlen = 32
) ();

  // core request
  logic            r_v;
  logic            w_v;
  logic [xlen-1:0] data_adr;
  logic [xlen-1:0] data_i;
  logic [3:0]      strobe;
  // core response
  logic [xlen-1:0] dmem_res;
  logic            dmem_res_v;
  logic            dmem_res_error;
  // data memory request
  logic            mem_r_v;
  logic            mem_w_v;
  logic [xlen-1:0] mem_adr;
  logic [xlen-1:0] mem_data;
  logic [3:0]      mem_strobe;
  // data memory response
  logic [xlen-1:0] mem_resp;
  logic            mem_resp_v;
  logic            mem_resp_error;

  // Environment view: drives core requests and memory responses
  modport master (
    output r_v, w_v, data_adr, data_i, strobe,
    input  dmem_res, dmem_res_v, dmem_res_error,
    input  mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
    output mem_resp, mem_resp_v, mem_resp_error
  );

  // Bridge view
  modport slave (
    input  r_v, w_v, data_adr, data_i, strobe,
    output dmem_res, dmem_res_v, dmem_res_error,
    output mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
    input  mem_resp, mem_resp_v, mem_resp_error
  );

endinterface

// File: rtl/sim_mmio_regs.sv
// Simulation host registers: exit, console and free-running cycle counter.
module sim_mmio_regs
  import sim_mmio_bridge_pkg::*;
#(
  parameter int unsigned xlen = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en_i,
  input  logic [3:0]      off_i,
  input  logic [xlen-1:0] wdata_i,
  input  logic            wstrb0_i,
  output logic [xlen-1:0] rd_data_c,
  output logic            off_err_c,
  output logic            exit_v_o,
  output logic [xlen-1:0] exit_code_o,
  output logic            console_v_o,
  output logic [7:0]      console_char_o
);

  logic               exit_v_q, exit_v_d;
  logic [xlen-1:0]    exit_code_q, exit_code_d;
  logic               console_v_q, console_v_d;
  logic [7:0]         console_char_q, console_char_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               exit_we_c;
  logic               con_we_c;

  // Only the first exit write is latched; later ones are acked without effect
  assign exit_we_c = wr_en_i && wstrb0_i && (off_i == EXIT) && !exit_v_q;
  assign con_we_c  = wr_en_i && wstrb0_i && (off_i == CONSOLE);

  // Read mux and offset decode for the response path
  always_comb begin
    rd_data_c = '0;
    off_err_c = 1'b0;
    case (off_i)
      EXIT, CONSOLE: rd_data_c = '0;
      CYCLE:         rd_data_c = xlen'(cycle_q);
      default:       off_err_c = 1'b1;
    endcase
  end

  // Next-state for host registers
  always_comb begin
    exit_v_d       = exit_v_q | exit_we_c;
    exit_code_d    = exit_we_c ? wdata_i : exit_code_q;
    console_v_d    = con_we_c;
    console_char_d = con_we_c ? wdata_i[7:0] : console_char_q;
    cycle_d        = cycle_q + CYCLE_W'(1);
  end

  // Register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exit_v_q       <= 1'b0;
      exit_code_q    <= '0;
      console_v_q    <= 1'b0;
      console_char_q <= '0;
      cycle_q        <= '0;
    end else begin
      exit_v_q       <= exit_v_d;
      exit_code_q    <= exit_code_d;
      console_v_q    <= console_v_d;
      console_char_q <= console_char_d;
      cycle_q        <= cycle_d;
    end
  end

  assign exit_v_o       = exit_v_q;
  assign exit_code_o    = exit_code_q;
  assign console_v_o    = console_v_q;
  assign console_char_o = console_char_q;

endmodule

// File: rtl/sim_mmio_bridge.sv
// Data-side decoder: routes core requests to data memory or the MMIO page.
module sim_mmio_bridge
  import sim_mmio_bridge_pkg::*;
#(
  parameter int unsigned     xlen      = XLEN,
  parameter logic [xlen-1:0] MEM_BASE  = xlen'(MEM_BASE_DEF),
  parameter int unsigned     MEM_SIZE  = MEM_SIZE_DEF,
  parameter logic [xlen-1:0] MMIO_BASE = xlen'(MMIO_BASE_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sim_mmio_bridge_if.slave      bus,
  output logic                  exit_v,
  output logic [xlen-1:0]       exit_code,
  output logic                  console_v,
  output logic [7:0]            console_char,
  output logic                  proto_err
);

  bridge_state_e   state_q, state_d;
  resp_t           resp_q, resp_d;
  logic            res_v_q, res_v_d;
  logic            proto_err_q, proto_err_d;

  logic            req_c, both_c, idle_c, accept_c;
  logic            is_mem_c, is_mmio_c;
  logic            fwd_c, mmio_acc_c, mem_done_c;
  logic [xlen-1:0] mem_off_c;
  logic [xlen-1:0] rd_data_c;
  logic            off_err_c;

  // Address decode; wrap-around subtraction makes below-base addresses huge
  assign mem_off_c  = bus.data_adr - MEM_BASE;
  assign is_mem_c   = mem_off_c < xlen'(MEM_SIZE);
  assign is_mmio_c  = bus.data_adr[xlen-1:4] == MMIO_BASE[xlen-1:4];

  assign req_c      = bus.r_v | bus.w_v;
  assign both_c     = bus.r_v & bus.w_v;
  assign idle_c     = state_q == IDLE;
  assign accept_c   = idle_c & req_c;
  assign fwd_c      = accept_c & ~both_c & is_mem_c;
  assign mmio_acc_c = accept_c & ~both_c & is_mmio_c;
  assign mem_done_c = (state_q == MEM_WAIT) & bus.mem_resp_v;

  sim_mmio_regs #(.xlen(xlen)) u_regs (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_i        (mmio_acc_c & bus.w_v),
    .off_i          (bus.data_adr[3:0]),
    .wdata_i        (bus.data_i),
    .wstrb0_i       (bus.strobe[0]),
    .rd_data_c      (rd_data_c),
    .off_err_c      (off_err_c),
    .exit_v_o       (exit_v),
    .exit_code_o    (exit_code),
    .console_v_o    (console_v),
    .console_char_o (console_char)
  );

  // FSM next state, registered MMIO/error response and sticky protocol error
  always_comb begin
    state_d     = state_q;
    resp_d      = '0;
    res_v_d     = 1'b0;
    proto_err_d = proto_err_q | (req_c & (~idle_c | both_c));
    case (state_q)
      IDLE: begin
        if (fwd_c) begin
          state_d = MEM_WAIT;
        end else if (accept_c) begin
          state_d = RESP;
          res_v_d = 1'b1;
          if (mmio_acc_c) begin
            resp_d.data  = rd_data_c;
            resp_d.error = off_err_c;
          end else begin
            resp_d.error = 1'b1;
          end
        end
      end
      MEM_WAIT: if (bus.mem_resp_v) state_d = IDLE;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      resp_q      <= '0;
      res_v_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_q      <= resp_d;
      res_v_q     <= res_v_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Memory forward is combinational and only during the accepted request cycle
  assign bus.mem_r_v    = fwd_c & bus.r_v;
  assign bus.mem_w_v    = fwd_c & bus.w_v;
  assign bus.mem_adr    = fwd_c ? bus.data_adr : '0;
  assign bus.mem_data   = fwd_c ? bus.data_i   : '0;
  assign bus.mem_strobe = fwd_c ? bus.strobe   : '0;

  // Memory response passes straight through; otherwise the registered reply
  assign bus.dmem_res_v     = res_v_q | mem_done_c;
  assign bus.dmem_res       = mem_done_c ? bus.mem_resp       : resp_q.data;
  assign bus.dmem_res_error = mem_done_c ? bus.mem_resp_error : resp_q.error;

  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sim_mmio_bridge.sv
// Scoreboard bench for sim_mmio_bridge: directed requests, queued expectations.
module tb_sim_mmio_bridge;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exit_v;
  logic [31:0] exit_code;
  logic        console_v;
  logic [7:0]  console_char;
  logic        proto_err;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  sim_mmio_bridge_if #(.xlen(32)) bus ();

  sim_mmio_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .exit_v       (exit_v),
    .exit_code    (exit_code),
    .console_v    (console_v),
    .console_char (console_char),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  // Response monitor: every dmem_res_v cycle must match the oldest expectation
  always @(negedge clk) begin
    if (bus.dmem_res_v === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: got data=%h err=%b, required no response",
                 bus.dmem_res, bus.dmem_res_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.dmem_res !== e.data || bus.dmem_res_error !== e.err) begin
          bad++;
          $display("FAIL resp: got data=%h err=%b, required data=%h err=%b",
                   bus.dmem_res, bus.dmem_res_error, e.data, e.err);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] adr,
                       input logic [31:0] d, input logic [3:0] s);
    bus.r_v      = r;
    bus.w_v      = w;
    bus.data_adr = adr;
    bus.data_i   = d;
    bus.strobe   = s;
  endtask

  task automatic clear_req();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // One-cycle request followed by release of the request lines
  task automatic do_req(input logic r, input logic w, input logic [31:0] adr,
                        input logic [31:0] d, input logic [3:0] s);
    drive(r, w, adr, d, s);
    tick(1);
    clear_req();
  endtask

  task automatic mem_resp(input logic [31:0] d, input logic e);
    bus.mem_resp_v     = 1'b1;
    bus.mem_resp       = d;
    bus.mem_resp_error = e;
    tick(1);
    bus.mem_resp_v     = 1'b0;
    bus.mem_resp       = 32'h0;
    bus.mem_resp_error = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", name, got, req);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_req();
    bus.mem_resp_v     = 1'b0;
    bus.mem_resp       = 32'h0;
    bus.mem_resp_error = 1'b0;
    tick(3);

    // Reset state
    check("rst_dmem_res_v", 32'(bus.dmem_res_v), 32'h0);
    check("rst_dmem_res",   bus.dmem_res, 32'h0);
    check("rst_exit_v",     32'(exit_v), 32'h0);
    check("rst_exit_code",  exit_code, 32'h0);
    check("rst_console_v",  32'(console_v), 32'h0);
    check("rst_proto_err",  32'(proto_err), 32'h0);
    check("rst_mem_r_v",    32'(bus.mem_r_v), 32'h0);

    // Cycle counter: a request sampled on the k-th edge after release reads k-1
    rst_n = 1'b1;
    tick(100);
    push(32'd100, 1'b0);
    do_req(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 4'h0);
    tick(9);
    push(32'd110, 1'b0);
    do_req(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 4'h0);
    tick(1);

    // Counter wrap: all-ones becomes 0 on the next edge
    force dut.u_regs.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_regs.cycle_q;
    tick(1);
    push(32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 4'h0);
    tick(1);

    // Exit register: first write latches, second ignored
    push(32'h0, 1'b0);
    do_req(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_002A, 4'hF);
    check("exit_v_set",  32'(exit_v), 32'h1);
    check("exit_code",   exit_code, 32'd42);
    tick(1);
    push(32'h0, 1'b0);
    do_req(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0007, 4'hF);
    check("exit_code_keep", exit_code, 32'd42);
    check("exit_v_sticky",  32'(exit_v), 32'h1);
    tick(1);

    // Console pulse and byte
    push(32'h0, 1'b0);
    do_req(1'b0, 1'b1, 32'hFFFF_FFF4, 32'h0000_0041, 4'hF);
    check("console_v_pulse", 32'(console_v), 32'h1);
    check("console_char",    32'(console_char), 32'h41);
    tick(1);
    check("console_v_drop",  32'(console_v), 32'h0);
    // Console write without byte-0 strobe has no effect
    push(32'h0, 1'b0);
    do_req(1'b0, 1'b1, 32'hFFFF_FFF4, 32'h0000_0042, 4'hE);
    check("console_nostrb_v",    32'(console_v), 32'h0);
    check("console_nostrb_char", 32'(console_char), 32'h41);
    tick(1);

    // MMIO reads: exit reads 0, reserved offset errors
    push(32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0);
    tick(1);
    push(32'h0, 1'b1);
    do_req(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
    tick(1);

    // Unmapped reads, including both window edges
    push(32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    #1 check("unmapped_no_fwd", 32'(bus.mem_r_v), 32'h0);
    tick(1);
    clear_req();
    tick(1);
    push(32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0002_4000, 32'h0, 4'h0);
    #1 check("above_win_no_fwd", 32'(bus.mem_r_v), 32'h0);
    tick(1);
    clear_req();
    tick(1);
    push(32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0001_FFFC, 32'h0, 4'h0);
    #1 check("below_win_no_fwd", 32'(bus.mem_r_v), 32'h0);
    tick(1);
    clear_req();
    tick(1);
    check("proto_err_clean", 32'(proto_err), 32'h0);

    // MEM read, latency 3, with a dropped second request on cycle 2
    drive(1'b1, 1'b0, 32'h0002_0010, 32'h0, 4'h0);
    #1;
    check("mem_r_v_fwd", 32'(bus.mem_r_v), 32'h1);
    check("mem_adr_fwd", bus.mem_adr, 32'h0002_0010);
    check("mem_w_v_idle", 32'(bus.mem_w_v), 32'h0);
    tick(1);
    clear_req();
    check("mem_r_v_one_cycle", 32'(bus.mem_r_v), 32'h0);
    tick(1);
    drive(1'b1, 1'b0, 32'h0002_0020, 32'h0, 4'h0);
    #1 check("busy_drop_no_fwd", 32'(bus.mem_r_v), 32'h0);
    tick(1);
    clear_req();
    check("busy_proto_err", 32'(proto_err), 32'h1);
    push(32'hCAFE_F00D, 1'b0);
    mem_resp(32'hCAFE_F00D, 1'b0);

    // Top-of-window write, error passed through, then back-to-back read
    drive(1'b0, 1'b1, 32'h0002_3FFC, 32'h1234_5678, 4'h3);
    #1;
    check("mem_w_v_fwd",    32'(bus.mem_w_v), 32'h1);
    check("mem_adr_top",    bus.mem_adr, 32'h0002_3FFC);
    check("mem_data_fwd",   bus.mem_data, 32'h1234_5678);
    check("mem_strobe_fwd", 32'(bus.mem_strobe), 32'h3);
    tick(1);
    clear_req();
    push(32'h0000_0055, 1'b1);
    mem_resp(32'h0000_0055, 1'b1);
    drive(1'b1, 1'b0, 32'h0002_0000, 32'h0, 4'h0);
    #1 check("b2b_mem_r_v", 32'(bus.mem_r_v), 32'h1);
    tick(1);
    clear_req();
    push(32'h0000_0011, 1'b0);
    mem_resp(32'h0000_0011, 1'b0);

    // Stray memory response while idle is discarded
    mem_resp(32'hBAD0_0001, 1'b0);
    tick(1);

    // Reset in MEM_WAIT clears everything; late response discarded
    drive(1'b1, 1'b0, 32'h0002_0100, 32'h0, 4'h0);
    tick(1);
    clear_req();
    rst_n = 1'b0;
    #1;
    check("rstw_dmem_res_v",  32'(bus.dmem_res_v), 32'h0);
    check("rstw_dmem_res",    bus.dmem_res, 32'h0);
    check("rstw_exit_v",      32'(exit_v), 32'h0);
    check("rstw_exit_code",   exit_code, 32'h0);
    check("rstw_console_chr", 32'(console_char), 32'h0);
    check("rstw_proto_err",   32'(proto_err), 32'h0);
    check("rstw_mem_r_v",     32'(bus.mem_r_v), 32'h0);
    tick(2);
    rst_n = 1'b1;
    mem_resp(32'hBAD0_0002, 1'b0);
    tick(1);

    // Both valids: error response, no memory access, protocol error
    push(32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'h0002_0000, 32'hFFFF_FFFF, 4'hF);
    #1;
    check("both_no_r_fwd", 32'(bus.mem_r_v), 32'h0);
    check("both_no_w_fwd", 32'(bus.mem_w_v), 32'h0);
    tick(1);
    clear_req();
    check("both_proto_err", 32'(proto_err), 32'h1);
    tick(2);

    // Every queued expectation must have been consumed
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_resp: got %0d outstanding, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
